// File: rtl/pipe_pkg.sv
// Shared state encoding for elastic pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam pipe_state_t PIPE_STATE_RST = EMPTY;

endpackage

// File: rtl/flopenr_n.sv
// Load-enabled register with async active-low clear; q updates one cycle after en.
// No flow control of its own: the owner decides when en is asserted.
module flopenr_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic stage with one-entry skid buffer; 1-cycle latency, full rate while out_ready is high.
// in_ready drops only when main and skid both hold words; optional flush input under PIPE_FLUSH_EN.
module pipe_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);
  import pipe_pkg::*;

  pipe_state_t      state, state_nxt;
  logic             in_fire, out_fire;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // The skid word moves up before any new input so ordering stays FIFO.
        if (out_fire) begin
          main_en   = 1'b1;
          main_d    = skid_q;
          state_nxt = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef PIPE_FLUSH_EN
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PIPE_STATE_RST;
    else        state <= state_nxt;
  end

  flopenr_n #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  flopenr_n #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
